// File: rtl/lock_ctrl.sv
// lock_ctrl: keypad code-lock sequencer. Collects a fixed-length code,
// checks it against a programmable stored code, and drives lock, lockout
// and programming state plus the digit buffer for the display.
module lock_ctrl #(
    parameter int unsigned          CLK_FREQ     = 50_000_000,
    parameter int unsigned          CODE_LEN     = 4,
    parameter int unsigned          MAX_FAIL     = 3,
    parameter int unsigned          UNLOCK_MS    = 5000,
    parameter int unsigned          LOCKOUT_MS   = 10000,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h4321
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_valid,
    input  logic [3:0]            key_value,
    input  logic                  prog_en,
    output logic [4*CODE_LEN-1:0] digits,
    output logic [3:0]            digit_count,
    output logic                  unlocked,
    output logic                  locked_out,
    output logic                  code_ok,
    output logic                  code_bad,
    output logic [3:0]            fail_count,
    output logic [2:0]            state
);

    localparam int unsigned DW         = 4 * CODE_LEN;
    localparam int unsigned CYC_PER_MS = CLK_FREQ / 1000;
    localparam int unsigned MAX_MS     = (UNLOCK_MS > LOCKOUT_MS) ? UNLOCK_MS : LOCKOUT_MS;
    localparam int unsigned PRE_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam int unsigned MS_W       = (MAX_MS > 1) ? $clog2(MAX_MS + 1) : 1;

    typedef enum logic [2:0] {
        S_LOCKED   = 3'd0,
        S_ENTRY    = 3'd1,
        S_CHECK    = 3'd2,
        S_UNLOCKED = 3'd3,
        S_PROG     = 3'd4,
        S_LOCKOUT  = 3'd5
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_digits;
    logic [DW-1:0]   r_code;
    logic [3:0]      r_count;
    logic [3:0]      r_fail;
    logic            r_unlocked;
    logic            r_locked_out;
    logic            r_code_ok;
    logic            r_code_bad;
    logic [PRE_W-1:0] r_pre;
    logic [MS_W-1:0]  r_ms;

    logic             w_key_digit;
    logic             w_key_clr;
    logic             w_key_ent;
    logic             w_room;
    logic             w_full;
    logic             w_match;
    logic [3:0]       w_fail_inc;
    logic             w_pre_wrap;
    logic             w_unlock_to;
    logic             w_lockout_to;
    logic [PRE_W-1:0] w_pre_nxt;
    logic [MS_W-1:0]  w_ms_nxt;
    logic [5:0]       w_nib_idx;

    // Key decode, buffer status and ms timer next values.
    assign w_key_digit  = key_valid && (key_value <= 4'hD);
    assign w_key_clr    = key_valid && (key_value == 4'hE);
    assign w_key_ent    = key_valid && (key_value == 4'hF);
    assign w_room       = r_count < 4'(CODE_LEN);
    assign w_full       = r_count == 4'(CODE_LEN);
    assign w_match      = w_full && (r_digits == r_code);
    assign w_fail_inc   = r_fail + 4'd1;
    assign w_nib_idx    = {r_count, 2'b00};
    assign w_pre_wrap   = r_pre == PRE_W'(CYC_PER_MS - 1);
    assign w_unlock_to  = w_pre_wrap && (r_ms == MS_W'(UNLOCK_MS - 1));
    assign w_lockout_to = w_pre_wrap && (r_ms == MS_W'(LOCKOUT_MS - 1));
    assign w_pre_nxt    = w_pre_wrap ? '0 : r_pre + PRE_W'(1);
    assign w_ms_nxt     = w_pre_wrap ? r_ms + MS_W'(1) : r_ms;

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_LOCKED;
            r_digits     <= '0;
            r_code       <= DEFAULT_CODE;
            r_count      <= '0;
            r_fail       <= '0;
            r_unlocked   <= 1'b0;
            r_locked_out <= 1'b0;
            r_code_ok    <= 1'b0;
            r_code_bad   <= 1'b0;
            r_pre        <= '0;
            r_ms         <= '0;
        end else begin
            r_code_ok  <= 1'b0;
            r_code_bad <= 1'b0;
            case (r_state)
                S_LOCKED: begin
                    if (w_key_digit) begin
                        r_digits <= DW'(key_value);
                        r_count  <= 4'd1;
                        r_state  <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (w_key_clr) begin
                        r_digits <= '0;
                        r_count  <= '0;
                        r_state  <= S_LOCKED;
                    end else if (w_key_ent) begin
                        r_state <= S_CHECK;
                    end else if (w_key_digit && w_room) begin
                        r_digits[w_nib_idx +: 4] <= key_value;
                        r_count                  <= r_count + 4'd1;
                    end
                end
                S_CHECK: begin
                    r_digits <= '0;
                    r_count  <= '0;
                    r_pre    <= '0;
                    r_ms     <= '0;
                    if (w_match) begin
                        r_code_ok  <= 1'b1;
                        r_fail     <= '0;
                        r_unlocked <= 1'b1;
                        r_state    <= S_UNLOCKED;
                    end else begin
                        r_code_bad <= 1'b1;
                        r_fail     <= w_fail_inc;
                        if (w_fail_inc == 4'(MAX_FAIL)) begin
                            r_locked_out <= 1'b1;
                            r_state      <= S_LOCKOUT;
                        end else begin
                            r_state <= S_LOCKED;
                        end
                    end
                end
                S_UNLOCKED: begin
                    if (w_unlock_to) begin
                        r_unlocked <= 1'b0;
                        r_state    <= S_LOCKED;
                    end else begin
                        r_pre <= w_pre_nxt;
                        r_ms  <= w_ms_nxt;
                        if (w_key_digit && prog_en) begin
                            r_digits <= DW'(key_value);
                            r_count  <= 4'd1;
                            r_state  <= S_PROG;
                        end
                    end
                end
                S_PROG: begin
                    if (!prog_en) begin
                        r_digits   <= '0;
                        r_count    <= '0;
                        r_unlocked <= 1'b0;
                        r_state    <= S_LOCKED;
                    end else if (w_key_ent || w_key_clr) begin
                        r_digits <= '0;
                        r_count  <= '0;
                        if (w_key_ent && w_full) begin
                            r_code     <= r_digits;
                            r_code_ok  <= 1'b1;
                            r_unlocked <= 1'b0;
                            r_state    <= S_LOCKED;
                        end else begin
                            r_pre   <= '0;
                            r_ms    <= '0;
                            r_state <= S_UNLOCKED;
                        end
                    end else if (w_key_digit && w_room) begin
                        r_digits[w_nib_idx +: 4] <= key_value;
                        r_count                  <= r_count + 4'd1;
                    end
                end
                S_LOCKOUT: begin
                    if (w_lockout_to) begin
                        r_fail       <= '0;
                        r_locked_out <= 1'b0;
                        r_state      <= S_LOCKED;
                    end else begin
                        r_pre <= w_pre_nxt;
                        r_ms  <= w_ms_nxt;
                    end
                end
                default: begin
                    r_state <= S_LOCKED;
                end
            endcase
        end
    end

    // Output mapping.
    assign digits      = r_digits;
    assign digit_count = r_count;
    assign unlocked    = r_unlocked;
    assign locked_out  = r_locked_out;
    assign code_ok     = r_code_ok;
    assign code_bad    = r_code_bad;
    assign fail_count  = r_fail;
    assign state       = r_state;

endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl: scoreboard bench for lock_ctrl with a behavioural lock model.
module tb_lock_ctrl;

    localparam int MAX_FAIL = 3;
    localparam int HOLD_UNL = 30;   // 3 ms at 10 cycles per ms
    localparam int HOLD_LO  = 50;   // 5 ms at 10 cycles per ms

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_value;
    logic        prog_en;
    logic [15:0] digits;
    logic [3:0]  digit_count;
    logic        unlocked;
    logic        locked_out;
    logic        code_ok;
    logic        code_bad;
    logic [3:0]  fail_count;
    logic [2:0]  state;

    lock_ctrl #(
        .CLK_FREQ    (10_000),
        .CODE_LEN    (4),
        .MAX_FAIL    (3),
        .UNLOCK_MS   (3),
        .LOCKOUT_MS  (5),
        .DEFAULT_CODE(16'h4321)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_value  (key_value),
        .prog_en    (prog_en),
        .digits     (digits),
        .digit_count(digit_count),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .code_ok    (code_ok),
        .code_bad   (code_bad),
        .fail_count (fail_count),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ok;
        int fail;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  ref_code[4];
    int  ref_fail;
    int  seq[$];
    int  newc[4];

    task automatic check(input string nm, input longint got, input longint expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, expv, $time);
        end
    endtask

    // Monitor: every result pulse must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (code_ok || code_bad)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {code_ok, code_bad}, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_ok", code_ok, e.ok);
                check("pulse_bad", code_bad, !e.ok);
                check("pulse_fail_count", fail_count, e.fail);
            end
        end
    end

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_value = k;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    // Counts cycles a status flag stays high while hammering keys every cycle.
    task automatic wait_hold(input bit lo, input int expc, input string nm);
        int cnt = 1;
        for (int i = 0; i < 300; i++) begin
            key_valid = 1'b1;
            key_value = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            key_valid = 1'b0;
            if (!(lo ? locked_out : unlocked)) break;
            cnt++;
        end
        check(nm, cnt, expc);
        check({nm, "_state"}, state, 0);
        check({nm, "_count"}, digit_count, 0);
        check({nm, "_flags"}, {unlocked, locked_out}, 0);
    endtask

    // Enters seq followed by enter and checks against the model.
    task automatic do_attempt(output bit matched);
        logic [15:0] ed = '0;
        int  n = seq.size();
        bit  m;
        foreach (seq[i]) key(4'(seq[i]));
        for (int i = 0; i < 4 && i < n; i++) ed[i*4 +: 4] = 4'(seq[i]);
        check("entry_digits", digits, ed);
        check("entry_count", digit_count, (n < 4) ? n : 4);
        check("entry_state", state, 1);
        key(4'hF);
        check("check_state", state, 2);
        m = (n >= 4);
        for (int i = 0; i < 4 && i < n; i++) if (seq[i] != ref_code[i]) m = 0;
        if (m) ref_fail = 0;
        else   ref_fail++;
        exp_q.push_back('{m, ref_fail});
        @(posedge clk); #1;
        check("post_digits", digits, 0);
        check("post_count", digit_count, 0);
        check("post_fail_count", fail_count, ref_fail);
        check("post_state", state, m ? 3 : ((ref_fail == MAX_FAIL) ? 5 : 0));
        check("post_unlocked", unlocked, m);
        check("post_locked_out", locked_out, !m && ref_fail == MAX_FAIL);
        #5;
        check("pulse_seen", exp_q.size(), 0);
        if (!m && ref_fail == MAX_FAIL) begin
            wait_hold(1'b1, HOLD_LO, "lockout_len");
            ref_fail = 0;
            check("lockout_fail_clr", fail_count, 0);
        end
        matched = m;
    endtask

    // Reprograms the code to newc; must be called just after an unlock.
    task automatic do_prog();
        logic [15:0] ed = '0;
        prog_en = 1'b1;
        foreach (newc[i]) begin
            key(4'(newc[i]));
            ed[i*4 +: 4] = 4'(newc[i]);
            if (i == 0) check("prog_state", state, 4);
        end
        check("prog_digits", digits, ed);
        check("prog_unlocked", unlocked, 1);
        exp_q.push_back('{1'b1, ref_fail});
        key(4'hF);
        check("prog_done_state", state, 0);
        check("prog_done_unl", unlocked, 0);
        check("prog_done_digits", digits, 0);
        #5;
        check("prog_pulse_seen", exp_q.size(), 0);
        prog_en = 1'b0;
        foreach (newc[i]) ref_code[i] = newc[i];
    endtask

    task automatic set_seq4(input int a, input int b, input int c, input int d);
        seq.delete();
        seq.push_back(a); seq.push_back(b); seq.push_back(c); seq.push_back(d);
    endtask

    task automatic check_reset(input string nm);
        check({nm, "_state"}, state, 0);
        check({nm, "_digits"}, digits, 0);
        check({nm, "_count"}, digit_count, 0);
        check({nm, "_fail"}, fail_count, 0);
        check({nm, "_flags"}, {unlocked, locked_out, code_ok, code_bad}, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit m;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_value = 4'h0;
        prog_en   = 1'b0;
        ref_code  = '{1, 2, 3, 4};
        ref_fail  = 0;
        #23;
        check_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clear and enter ignored while locked.
        key(4'hE); key(4'hF);
        check("locked_ignore", state, 0);

        // Correct code, full unlock hold.
        set_seq4(1, 2, 3, 4);
        do_attempt(m);
        wait_hold(1'b0, HOLD_UNL, "unlock_len");

        // Three wrong codes into lockout.
        for (int r = 0; r < 3; r++) begin
            set_seq4(1, 2, 3, 5);
            do_attempt(m);
        end

        // Short entry then over-long correct entry.
        seq.delete(); seq.push_back(1); seq.push_back(2);
        do_attempt(m);
        set_seq4(1, 2, 3, 4); seq.push_back(5);
        do_attempt(m);
        wait_hold(1'b0, HOLD_UNL, "unlock_len2");

        // Clear during entry.
        key(4'h1); key(4'h2); key(4'hE);
        check("clear_state", state, 0);
        check("clear_digits", digits, 0);
        check("clear_count", digit_count, 0);

        // Reprogram to 9,8,7,6; old code rejected, new accepted.
        set_seq4(1, 2, 3, 4);
        do_attempt(m);
        newc = '{9, 8, 7, 6};
        do_prog();
        set_seq4(1, 2, 3, 4);
        do_attempt(m);
        set_seq4(9, 8, 7, 6);
        do_attempt(m);

        // Aborted programming returns to unlocked with a reloaded timer.
        prog_en = 1'b1;
        key(4'h5); key(4'hE);
        check("abort_state", state, 3);
        prog_en = 1'b0;
        wait_hold(1'b0, HOLD_UNL, "abort_reload_len");

        // prog_en drop coincident with a key: exit wins, code kept.
        set_seq4(9, 8, 7, 6);
        do_attempt(m);
        prog_en = 1'b1;
        key(4'h5);
        prog_en = 1'b0;
        key(4'h7);
        check("progdrop_state", state, 0);
        check("progdrop_digits", digits, 0);

        // Randomised attempts against the model.
        for (int it = 0; it < 25; it++) begin
            seq.delete();
            if ($urandom_range(0, 1) == 1) begin
                foreach (ref_code[i]) seq.push_back(ref_code[i]);
                if ($urandom_range(0, 2) == 0) seq.push_back(int'($urandom_range(0, 13)));
            end else begin
                for (int i = 0; i < int'($urandom_range(1, 6)); i++)
                    seq.push_back(int'($urandom_range(0, 13)));
            end
            do_attempt(m);
            if (m) begin
                if ($urandom_range(0, 1) == 1) begin
                    wait_hold(1'b0, HOLD_UNL, "rnd_unlock_len");
                end else begin
                    foreach (newc[i]) newc[i] = int'($urandom_range(0, 13));
                    do_prog();
                end
            end
        end

        // Reset mid-entry discards the programmed code and the fail count.
        set_seq4(1, 2, 3, 4);
        do_attempt(m);
        if (m) wait_hold(1'b0, HOLD_UNL, "pre_reset_unlock");
        set_seq4(1, 2, 3, 4);
        do_attempt(m);
        if (m) begin
            newc = '{9, 8, 7, 6};
            do_prog();
        end
        seq.delete(); seq.push_back(0);
        do_attempt(m);
        key(4'h1); key(4'h2);
        #2 rst_n = 1'b0;
        #1;
        check_reset("midreset");
        @(posedge clk); #1;
        rst_n    = 1'b1;
        ref_code = '{1, 2, 3, 4};
        ref_fail = 0;
        exp_q.delete();
        @(posedge clk); #1;
        set_seq4(1, 2, 3, 4);
        do_attempt(m);
        check("reset_default_unlock", m, 1);
        wait_hold(1'b0, HOLD_UNL, "final_unlock_len");

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Sequencing controller for the keypad digital lock. Consumes debounced single-cycle key events from the keypad path and collects a fixed-length code. Compares the code against a programmable stored code and drives lock, lockout and programming state. Its digit buffer feeds the SSD display muxing, and its status outputs feed the RGB/LED indicators.

## Interface
- CLK_FREQ, 50_000_000, clock frequency in Hz; must be divisible by 1000
- CODE_LEN, 4, digits per code (1..8)
- MAX_FAIL, 3, consecutive bad attempts before lockout (1..15)
- UNLOCK_MS, 5000, unlocked hold time in ms
- LOCKOUT_MS, 10000, lockout time in ms
- DEFAULT_CODE, 16'h4321, reset code, 4*CODE_LEN bits; nibble i = i-th digit entered
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle pulse per debounced key press
- key_value  in  4  decoded key, valid when key_valid=1; 0x0-0xD digit, 0xE clear, 0xF enter
- prog_en  in  1  level switch; enables code reprogramming while unlocked
- digits  out  4*CODE_LEN  entered digits, nibble i = i-th entered, unentered nibbles 0
- digit_count  out  4  number of digits held in buffer
- unlocked  out  1  lock open
- locked_out  out  1  lockout active, all keys ignored
- code_ok  out  1  one-cycle pulse: correct code accepted or new code stored
- code_bad  out  1  one-cycle pulse: attempt rejected
- fail_count  out  4  consecutive failed attempts
- state  out  3  FSM state: LOCKED=0, ENTRY=1, CHECK=2, UNLOCKED=3, PROG=4, LOCKOUT=5

## Operation
- Reset: state=LOCKED, digits=0, digit_count=0, fail_count=0, all flags/pulses 0, stored code=DEFAULT_CODE. Reset mid-operation discards any reprogrammed code.
- All outputs are registered. code_ok and code_bad are high for exactly one cycle.
- LOCKED
  - digit key: store at nibble 0, count=1, go to ENTRY.
  - clear and enter keys are ignored.
- ENTRY
  - digit key: stored at nibble digit_count only while count<CODE_LEN; further digits are ignored.
  - clear: buffer and count zeroed, go to LOCKED.
  - enter: go to CHECK.
- CHECK (one cycle)
  - Match requires count==CODE_LEN and buffer==stored code; a short entry is a mismatch.
  - Match: code_ok, fail_count=0, go to UNLOCKED.
  - Mismatch: code_bad, fail_count+1. Go to LOCKOUT if the new count equals MAX_FAIL, else to LOCKED.
  - Either outcome clears buffer and count.
- UNLOCKED
  - unlocked=1; the timer runs from entry.
  - digit key with prog_en=1: store at nibble 0, go to PROG.
  - All other keys are ignored.
  - At timeout go to LOCKED.
- PROG
  - unlocked stays 1; the timer is frozen and reloaded on return to UNLOCKED.
  - Digits accumulate as in ENTRY.
  - enter with count==CODE_LEN: stored code=buffer, code_ok, go to LOCKED.
  - enter with short count, or clear: discard, go to UNLOCKED.
  - prog_en falling to 0: discard, go to LOCKED.
  - Buffer is cleared on every exit.
- LOCKOUT
  - locked_out=1; all keys ignored.
  - At timeout: fail_count=0, go to LOCKED.
- Timer: a ms prescaler (CLK_FREQ/1000 cycles) plus a ms counter, both zeroed on entry to UNLOCKED or LOCKOUT.

## Timing
- key_valid at cycle N: digits/digit_count/state updated at N+1.
- enter at N: state=CHECK at N+1; unlocked or code_bad, fail_count and cleared buffer at N+2.
- unlocked stays high for exactly UNLOCK_MS*CLK_FREQ/1000 cycles from the cycle it rises when PROG is not entered. locked_out behaves the same with LOCKOUT_MS.
- Timeout coincident with key_valid: the timeout wins and the key is dropped.
- prog_en falling coincident with key_valid in PROG: the prog_en exit wins.
- key_valid during CHECK is dropped.
- Back-to-back key_valid on consecutive cycles must each be processed.

## Test plan
Bench parameters: CLK_FREQ=10_000, CODE_LEN=4, MAX_FAIL=3, UNLOCK_MS=3, LOCKOUT_MS=5, DEFAULT_CODE=16'h4321.
- Keys 1,2,3,4,F: digits=16'h4321 and count=4 before F. Two cycles after F: code_ok pulse, unlocked=1, state=3. unlocked holds exactly 30 cycles, then state=0.
- Keys 1,2,3,5,F three times: three code_bad pulses, fail_count 1→2→3. locked_out=1 for exactly 50 cycles with keys ignored, then fail_count=0, state=0.
- Keys 1,2,F: code_bad, fail_count=1. Keys 1,2,3,4,5,F: fifth digit ignored, accepted, fail_count=0.
- Keys 1,2,E: buffer cleared, state=0, no pulse.
- Unlock, then prog_en=1, keys 9,8,7,6,F: code_ok, state=0. Old code 1,2,3,4,F is rejected; 9,8,7,6,F unlocks.
- New code stored, then rst_n low mid-ENTRY: all outputs return to reset values; 1,2,3,4,F unlocks again.
